// File: rtl/arb8_rr_ctrl.sv
// arb8_rr_ctrl: 8-requester arbiter with registered one-hot grant, hold-until-release,
// fixed-priority / round-robin selection and a hold-time watchdog.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   async active-low reset
//   en       in   arbitration enable (only gates new grants)
//   mode     in   0 fixed priority (req[7] top), 1 round-robin
//   req[7:0] in   level request lines
//   done     in   owner release pulse (ignored when idle)
//   gnt[7:0] out  one-hot grant, zero when idle
//   gnt_idx  out  binary owner index, 0 when idle
//   gnt_vld  out  grant held
//   timeout  out  1-cycle pulse in the gap after a watchdog release
module arb8_rr_ctrl #(
  parameter int HOLD_MAX = 16,
  parameter int CW       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] HM  = CW'(HOLD_MAX);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        r_state;
  logic [7:0]    r_gnt;
  logic [2:0]    r_idx;
  logic          r_vld;
  logic          r_to;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_ptr;

  logic [2:0] w_fix_idx;
  logic [2:0] w_rr_idx;
  logic [2:0] w_scan;
  logic       w_rr_hit;
  logic [2:0] w_win;
  logic       w_wd_hit;
  logic       w_rel_done;
  logic       w_rel_wd;
  logic       w_rel_req;
  logic       w_hold;

  // Fixed priority: later (higher) indices overwrite lower ones.
  always_comb begin
    w_fix_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) w_fix_idx = 3'(i);
    end
  end

  // Round-robin: first request scanning up from ptr+1, wrapping.
  always_comb begin
    w_rr_idx = 3'd0;
    w_rr_hit = 1'b0;
    w_scan   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      w_scan = r_ptr + 3'(k);
      if (!w_rr_hit && req[w_scan]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_scan;
      end
    end
  end

  assign w_win = mode ? w_rr_idx : w_fix_idx;

  assign w_wd_hit = (HOLD_MAX != 0) && (r_cnt == HM);

  // Mutually exclusive release causes, done winning over the others.
  assign w_rel_done = done;
  assign w_rel_req  = !done && !req[r_idx];
  assign w_rel_wd   = !done && req[r_idx] && w_wd_hit;
  assign w_hold     = !done && req[r_idx] && !w_wd_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 8'd0;
      r_idx   <= 3'd0;
      r_vld   <= 1'b0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= 3'd7;
    end else begin
      r_to <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (en && (req != 8'd0)) begin
            r_state <= GRANT;
            r_gnt   <= 8'd1 << w_win;
            r_idx   <= w_win;
            r_vld   <= 1'b1;
            r_cnt   <= ONE;
          end
        end
        GRANT: begin
          unique case (1'b1)
            w_hold: begin
              r_cnt <= r_cnt + ONE;
            end
            w_rel_done, w_rel_req, w_rel_wd: begin
              r_state <= IDLE;
              r_gnt   <= 8'd0;
              r_idx   <= 3'd0;
              r_vld   <= 1'b0;
              r_cnt   <= '0;
              r_ptr   <= r_idx;
              r_to    <= w_rel_wd;
            end
          endcase
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;
  assign timeout = r_to;

endmodule

// File: tb/tb_arb8_rr_ctrl.sv
// tb_arb8_rr_ctrl: directed self-checking bench for arb8_rr_ctrl.
// Main DUT uses HOLD_MAX=4; a second instance has the watchdog disabled.
module tb_arb8_rr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  logic       en0;
  logic [7:0] req0;
  logic       done0;
  logic [7:0] gnt0;
  logic [2:0] gnt_idx0;
  logic       gnt_vld0;
  logic       timeout0;

  int n_chk  = 0;
  int n_fail = 0;

  arb8_rr_ctrl #(.HOLD_MAX(4), .CW(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .timeout(timeout)
  );

  arb8_rr_ctrl #(.HOLD_MAX(0), .CW(5)) dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en0),
    .mode   (1'b0),
    .req    (req0),
    .done   (done0),
    .gnt    (gnt0),
    .gnt_idx(gnt_idx0),
    .gnt_vld(gnt_vld0),
    .timeout(timeout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_g(input string tag, input logic [7:0] eg,
                       input logic [2:0] ei, input logic ev,
                       input logic et);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
    chk({tag, ".vld"}, 32'(gnt_vld), 32'(ev));
    chk({tag, ".to"}, 32'(timeout), 32'(et));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    en0   = 1'b0;
    req0  = 8'h00;
    done0 = 1'b0;
    step();
    step();
    chk_g("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // 1: async reset mid-grant
    mode = 1'b0;
    en   = 1'b1;
    req  = 8'h08;
    step();
    chk_g("t1_grant", 8'h08, 3'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_g("t1_async", 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 8'hFF;
    step();
    chk_g("t1_first_rr", 8'h01, 3'd0, 1'b1, 1'b0);

    // 3: round-robin sweep 1..7 then 0
    for (int i = 1; i <= 8; i++) begin
      done = 1'b1;
      step();
      done = 1'b0;
      chk("t3_gap", 32'(gnt_vld), 32'd0);
      step();
      chk("t3_idx", 32'(gnt_idx), 32'(i % 8));
      chk("t3_gnt", 32'(gnt), 32'(1 << (i % 8)));
    end
    done = 1'b1;
    step();
    done = 1'b0;

    // 2: fixed priority
    mode = 1'b0;
    req  = 8'b1010_0100;
    step();
    chk_g("t2_grant", 8'h80, 3'd7, 1'b1, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk_g("t2_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk_g("t2_regrant", 8'h80, 3'd7, 1'b1, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;

    // 4: watchdog, set ptr=2 first
    req = 8'h04;
    step();
    chk("t4_p2", 32'(gnt_idx), 32'd2);
    done = 1'b1;
    step();
    done = 1'b0;
    mode = 1'b1;
    req  = 8'b0010_1000;
    step();
    chk_g("t4_c1", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    step();
    step();
    chk_g("t4_c4", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_g("t4_to", 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    chk_g("t4_next", 8'h20, 3'd5, 1'b1, 1'b0);
    step();
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    chk_g("t4_done_wd", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk_g("t4_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // 5: enable / withdraw
    en  = 1'b0;
    req = 8'h10;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_en0", 32'(gnt_vld), 32'd0);
    end
    en = 1'b1;
    step();
    chk_g("t5_grant", 8'h10, 3'd4, 1'b1, 1'b0);
    en = 1'b0;
    step();
    step();
    chk_g("t5_hold", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk_g("t5_withdraw", 8'h00, 3'd0, 1'b0, 1'b0);
    en = 1'b1;

    // 6: wrap-around
    mode = 1'b1;
    req  = 8'h80;
    step();
    chk("t6_g7", 32'(gnt_idx), 32'd7);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'b1000_0001;
    step();
    chk_g("t6_wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk_g("t6_back7", 8'h80, 3'd7, 1'b1, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;

    // watchdog disabled: long hold, no timeout
    en0  = 1'b1;
    req0 = 8'h01;
    for (int i = 0; i < 20; i++) step();
    chk("wd0_gnt", 32'(gnt0), 32'h01);
    chk("wd0_to", 32'(timeout0), 32'd0);
    req0 = 8'h00;
    step();
    chk("wd0_rel", 32'(gnt_vld0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
